// File: rtl/msg_scroller.sv
// Scrolling-message engine: holds MSG_LEN hex nibbles and presents a DIGITS-wide
// window for the front-panel driver, advanced by an internal clock-enable prescaler.
module msg_scroller #(
    parameter int DIGITS  = 8,
    parameter int MSG_LEN = 16,
    parameter int DIV     = 25_000_000,
    parameter logic [MSG_LEN*4-1:0] INIT = 64'h0123456789ABCDEF,
    localparam int PW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                wr_en,
    input  logic [PW-1:0]       wr_addr,
    input  logic [3:0]          wr_data,
    output logic [DIGITS*4-1:0] seg,
    output logic [PW-1:0]       pos,
    output logic                step
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(MSG_LEN - 1);
    localparam logic [PW-1:0] POS_MAX  = PW'(MSG_LEN - DIGITS);

    logic [3:0]    msg [MSG_LEN];
    logic [CW-1:0] cnt, cnt_nxt;
    logic [PW-1:0] pos_nxt;
    logic          dir, dir_nxt;
    logic          run, tick;

    always_comb begin
        run     = en && (mode != 2'b00);
        tick    = run && (cnt == CNT_LAST);
        cnt_nxt = cnt;
        pos_nxt = pos;
        dir_nxt = dir;
        if (run) begin
            cnt_nxt = tick ? '0 : cnt + 1'b1;
        end
        if (tick) begin
            case (mode)
                2'b01: pos_nxt = (pos == POS_LAST) ? '0 : pos + 1'b1;
                2'b10: pos_nxt = (pos == '0) ? POS_LAST : pos - 1'b1;
                2'b11: begin
                    // Entering bounce from a left/right offset past the last full window
                    if (pos > POS_MAX) begin
                        pos_nxt = POS_MAX;
                        dir_nxt = 1'b0;
                    end else if (MSG_LEN == DIGITS) begin
                        pos_nxt = '0;
                    end else if (dir) begin
                        if (pos < POS_MAX) begin
                            pos_nxt = pos + 1'b1;
                        end else begin
                            dir_nxt = 1'b0;
                            pos_nxt = POS_MAX - 1'b1;
                        end
                    end else begin
                        if (pos > '0) begin
                            pos_nxt = pos - 1'b1;
                        end else begin
                            dir_nxt = 1'b1;
                            pos_nxt = PW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            pos  <= '0;
            dir  <= 1'b1;
            step <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) begin
                msg[i] <= INIT[4*(MSG_LEN-1-i) +: 4];
            end
        end else begin
            cnt  <= cnt_nxt;
            pos  <= pos_nxt;
            dir  <= dir_nxt;
            step <= tick;
            if (wr_en && (int'(wr_addr) < MSG_LEN)) begin
                msg[wr_addr] <= wr_data;
            end
        end
    end

    // Window wraps around the message end; pos is always below MSG_LEN
    always_comb begin
        seg = '0;
        for (int k = 0; k < DIGITS; k++) begin
            int idx;
            idx = int'(pos) + k;
            if (idx >= MSG_LEN) idx = idx - MSG_LEN;
            seg[4*k +: 4] = msg[idx];
        end
    end

endmodule

// File: tb/tb_msg_scroller.sv
// Directed bench for msg_scroller with a 4-digit window over a 6-nibble message.
module tb_msg_scroller;

    localparam int DIGITS  = 4;
    localparam int MSG_LEN = 6;
    localparam int DIV     = 4;
    localparam int PW      = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic [1:0]          mode;
    logic                wr_en;
    logic [PW-1:0]       wr_addr;
    logic [3:0]          wr_data;
    logic [DIGITS*4-1:0] seg;
    logic [PW-1:0]       pos;
    logic                step;

    int tests = 0;
    int fails = 0;

    msg_scroller #(
        .DIGITS (DIGITS),
        .MSG_LEN(MSG_LEN),
        .DIV    (DIV),
        .INIT   (24'h012345)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .seg    (seg),
        .pos    (pos),
        .step   (step)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; mode = 2'b00;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 2'b00;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cyc(2);
        tests++; if (seg !== 16'h3210) begin fails++; $display("FAIL reset_seg: got %h expected %h", seg, 16'h3210); end
        tests++; if (pos !== 3'd0) begin fails++; $display("FAIL reset_pos: got %0d expected 0", pos); end
        tests++; if (step !== 1'b0) begin fails++; $display("FAIL reset_step: got %b expected 0", step); end
        rst_n = 1'b1; mode = 2'b01; en = 1'b1;
        cyc(14);
        tests++; if (pos !== 3'd3) begin fails++; $display("FAIL reset_pre_pos: got %0d expected 3", pos); end
        rst_n = 1'b0;
        #1;
        tests++; if (pos !== 3'd0) begin fails++; $display("FAIL reset_async_pos: got %0d expected 0", pos); end
        tests++; if (seg !== 16'h3210) begin fails++; $display("FAIL reset_async_seg: got %h expected %h", seg, 16'h3210); end
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        tests++; if (step !== 1'b0 || pos !== 3'd0) begin fails++; $display("FAIL reset_restart_early: got step=%b pos=%0d expected step=0 pos=0", step, pos); end
        cyc(1);
        tests++; if (step !== 1'b1 || pos !== 3'd1) begin fails++; $display("FAIL reset_restart_tick: got step=%b pos=%0d expected step=1 pos=1", step, pos); end
    endtask

    task automatic test_left();
        do_reset();
        mode = 2'b01; en = 1'b1;
        cyc(3);
        tests++; if (step !== 1'b0 || pos !== 3'd0) begin fails++; $display("FAIL left_pre: got step=%b pos=%0d expected step=0 pos=0", step, pos); end
        cyc(1);
        tests++; if (step !== 1'b1 || pos !== 3'd1) begin fails++; $display("FAIL left_s1: got step=%b pos=%0d expected step=1 pos=1", step, pos); end
        tests++; if (seg !== 16'h4321) begin fails++; $display("FAIL left_s1_seg: got %h expected %h", seg, 16'h4321); end
        cyc(1);
        tests++; if (step !== 1'b0) begin fails++; $display("FAIL left_pulse_width: got %b expected 0", step); end
        cyc(15);
        tests++; if (step !== 1'b1 || pos !== 3'd5) begin fails++; $display("FAIL left_s5: got step=%b pos=%0d expected step=1 pos=5", step, pos); end
        tests++; if (seg !== 16'h2105) begin fails++; $display("FAIL left_s5_seg: got %h expected %h", seg, 16'h2105); end
        cyc(4);
        tests++; if (pos !== 3'd0 || seg !== 16'h3210) begin fails++; $display("FAIL left_s6_wrap: got pos=%0d seg=%h expected pos=0 seg=3210", pos, seg); end
    endtask

    task automatic test_right();
        do_reset();
        mode = 2'b10; en = 1'b1;
        cyc(4);
        tests++; if (pos !== 3'd5 || seg !== 16'h2105) begin fails++; $display("FAIL right_s1: got pos=%0d seg=%h expected pos=5 seg=2105", pos, seg); end
        cyc(4);
        tests++; if (pos !== 3'd4 || seg !== 16'h1054) begin fails++; $display("FAIL right_s2: got pos=%0d seg=%h expected pos=4 seg=1054", pos, seg); end
    endtask

    task automatic test_bounce();
        logic [PW-1:0] exp_b [6] = '{3'd1, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
        do_reset();
        mode = 2'b11; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(4);
            tests++; if (pos !== exp_b[i]) begin fails++; $display("FAIL bounce_seq%0d: got %0d expected %0d", i, pos, exp_b[i]); end
        end
        do_reset();
        mode = 2'b01; en = 1'b1;
        cyc(20);
        tests++; if (pos !== 3'd5) begin fails++; $display("FAIL bounce_pre_left: got %0d expected 5", pos); end
        mode = 2'b11;
        cyc(4);
        tests++; if (pos !== 3'd2) begin fails++; $display("FAIL bounce_clamp: got %0d expected 2", pos); end
        cyc(4);
        tests++; if (pos !== 3'd1) begin fails++; $display("FAIL bounce_clamp_dir: got %0d expected 1", pos); end
    endtask

    task automatic test_write();
        do_reset();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hF;
        cyc(1);
        wr_en = 1'b0;
        tests++; if (seg !== 16'h3F10) begin fails++; $display("FAIL write_seg: got %h expected %h", seg, 16'h3F10); end
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 4'h7;
        cyc(1);
        wr_addr = 3'd7;
        cyc(1);
        wr_en = 1'b0;
        tests++; if (seg !== 16'h3F10 || pos !== 3'd0) begin fails++; $display("FAIL write_oob: got seg=%h pos=%0d expected seg=3f10 pos=0", seg, pos); end
    endtask

    task automatic test_write_tick();
        do_reset();
        mode = 2'b01; en = 1'b1;
        cyc(3);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'hA;
        cyc(1);
        wr_en = 1'b0;
        tests++; if (pos !== 3'd1 || step !== 1'b1) begin fails++; $display("FAIL wrtick_pos: got pos=%0d step=%b expected pos=1 step=1", pos, step); end
        tests++; if (seg !== 16'h432A) begin fails++; $display("FAIL wrtick_seg: got %h expected %h", seg, 16'h432A); end
    endtask

    task automatic test_en_pause();
        int n = 0;
        int moved = 0;
        do_reset();
        mode = 2'b01; en = 1'b1;
        cyc(4);
        tests++; if (step !== 1'b1 || pos !== 3'd1) begin fails++; $display("FAIL pause_ref: got step=%b pos=%0d expected step=1 pos=1", step, pos); end
        while (n < 40) begin
            cyc(1);
            n++;
            if (step === 1'b1) break;
            if (pos !== 3'd1) moved++;
            if (n == 2) en = 1'b0;
            if (n == 12) en = 1'b1;
        end
        tests++; if (n != 14) begin fails++; $display("FAIL pause_interval: got %0d cycles expected 14", n); end
        tests++; if (moved != 0) begin fails++; $display("FAIL pause_hold: got %0d moves expected 0", moved); end
        tests++; if (pos !== 3'd2) begin fails++; $display("FAIL pause_after: got %0d expected 2", pos); end
    endtask

    initial begin
        test_reset();
        test_left();
        test_right();
        test_bounce();
        test_write();
        test_write_tick();
        test_en_pause();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
